pattern_sequencer: RTL

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

---
 rtl/pattern_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pattern_sequencer.sv
// Cycles through NUM_PATTERNS test-pattern generators, dwelling a programmable
// number of frames on each; switches (auto or manual) only take effect at pixel origin.
module pattern_sequencer #(
    parameter int NUM_PATTERNS = 4,
    parameter int FRAME_W      = 10,
    parameter logic [NUM_PATTERNS*FRAME_W-1:0] DWELL_TABLE =
        {10'd480, 10'd240, 10'd480, 10'd240}
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    input  logic                      active,
    input  logic                      vsync,
    input  logic                      paused,
    input  logic                      hold,
    input  logic                      manual_mode,
    input  logic                      manual_req,
    input  logic [2:0]                manual_sel,
    input  logic [NUM_PATTERNS*6-1:0] pattern_rgb,
    output logic [NUM_PATTERNS-1:0]   pattern_enable,
    output logic [NUM_PATTERNS-1:0]   active_out,
    output logic [NUM_PATTERNS-1:0]   next_frame,
    output logic [5:0]                rgb,
    output logic [2:0]                cur_pattern,
    output logic [FRAME_W-1:0]        frame_count,
    output logic                      switch_pulse
);

    logic [2:0]         cur_q, cur_d;
    logic [2:0]         target_q, target_d;
    logic               pending_q, pending_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               vsync_q, vsync_d;
    logic               switch_q, switch_d;

    logic               vsync_rise;
    logic [FRAME_W-1:0] dwell;
    logic [FRAME_W-1:0] dwell_last;
    logic               auto_step;
    logic               auto_expire;
    logic               manual_ok;
    logic               commit;
    logic [2:0]         next_idx;
    logic [5:0]         cur_rgb;

    assign vsync_rise = vsync & ~vsync_q;

    always_comb begin
        dwell   = '0;
        cur_rgb = '0;
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            if (cur_q == 3'(i)) begin
                dwell   = DWELL_TABLE[i*FRAME_W +: FRAME_W];
                cur_rgb = pattern_rgb[i*6 +: 6];
            end
        end
    end

    // A zero dwell is treated as one frame, so its last index is also 0.
    assign dwell_last  = (dwell == '0) ? '0 : dwell - FRAME_W'(1);
    assign auto_step   = ~manual_mode & ~hold & vsync_rise;
    assign auto_expire = auto_step & (frame_q == dwell_last);
    assign manual_ok   = manual_req & ({1'b0, manual_sel} < 4'(NUM_PATTERNS))
                       & (manual_sel != cur_q);
    assign commit      = pending_q & (x == 10'd0) & (y == 10'd0);
    assign next_idx    = (cur_q == 3'(NUM_PATTERNS - 1)) ? 3'd0 : cur_q + 3'd1;

    always_comb begin
        cur_d     = cur_q;
        target_d  = target_q;
        pending_d = pending_q;
        frame_d   = frame_q;
        vsync_d   = vsync;
        switch_d  = 1'b0;

        if (auto_step) begin
            frame_d = auto_expire ? '0 : frame_q + FRAME_W'(1);
        end
        if (auto_expire) begin
            pending_d = 1'b1;
            target_d  = next_idx;
        end
        if (manual_ok) begin
            pending_d = 1'b1;
            target_d  = manual_sel;
        end
        // Commit overrides everything else in the cycle, including a vsync increment.
        if (commit) begin
            cur_d     = target_q;
            target_d  = target_q;
            pending_d = 1'b0;
            frame_d   = '0;
            switch_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q     <= '0;
            target_q  <= '0;
            pending_q <= 1'b0;
            frame_q   <= '0;
            vsync_q   <= 1'b1;
            switch_q  <= 1'b0;
        end else begin
            cur_q     <= cur_d;
            target_q  <= target_d;
            pending_q <= pending_d;
            frame_q   <= frame_d;
            vsync_q   <= vsync_d;
            switch_q  <= switch_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PATTERNS; g++) begin : g_lane
            assign pattern_enable[g] = (cur_q == 3'(g));
            assign active_out[g]     = active & (cur_q == 3'(g));
            assign next_frame[g]     = vsync_rise & ~paused & (cur_q == 3'(g));
        end
    endgenerate

    assign rgb          = active ? cur_rgb : 6'b0;
    assign cur_pattern  = cur_q;
    assign frame_count  = frame_q;
    assign switch_pulse = switch_q;

endmodule
